mem_access_ctrl: RTL and testbench

// - Memory-stage responder for the EX/MEM pipeline register. It consumes that register's

---
 rtl/mem_access_if.sv | 34 +++
 rtl/mem_access_ctrl.sv | 94 +++++++++
 tb/tb_mem_access_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// mem_access_if: EX/MEM request, data memory and MEM/WB response signals
// grouped for the memory-stage access controller.
interface mem_access_if;
  logic [15:0] Addr_m;
  logic [15:0] WriteData_m;
  logic        MemRead_m;
  logic        MemWrite_m;
  logic        halt_m;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_en_o;
  logic        mem_wr_o;
  logic        stall_o;
  logic        complete_o;
  logic [15:0] rdata_o;
  logic        err_o;
  logic        halted_o;

  modport slave (
    input  Addr_m, WriteData_m, MemRead_m, MemWrite_m, halt_m,
    input  mem_rdata, mem_done,
    output mem_addr_o, mem_wdata_o, mem_en_o, mem_wr_o,
    output stall_o, complete_o, rdata_o, err_o, halted_o
  );

  modport master (
    output Addr_m, WriteData_m, MemRead_m, MemWrite_m, halt_m,
    output mem_rdata, mem_done,
    input  mem_addr_o, mem_wdata_o, mem_en_o, mem_wr_o,
    input  stall_o, complete_o, rdata_o, err_o, halted_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage controller driving a multi-cycle data memory.
// Optional ALIGN_CHK_EN rejects odd-address requests without a memory access.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, wdata_q;
  logic        wr_q, en_q, halt_q, err_q;
  logic        req, misalign, issue, done, tmo, finish;

  assign req = bus.MemRead_m | bus.MemWrite_m;

`ifdef ALIGN_CHK_EN
  assign misalign = (state_q == S_IDLE) & req & bus.Addr_m[0];
`else
  assign misalign = 1'b0;
`endif

  assign issue  = (state_q == S_IDLE) & req & ~misalign;
  assign done   = (state_q == S_WAIT) & bus.mem_done;
  assign tmo    = (state_q == S_WAIT) & ~bus.mem_done
                & (cnt_q == CNT_MAX);
  assign finish = done | tmo;

  // Next state and wait counter; a timed-out access retires like a done one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (bus.halt_m & ~req) begin
          state_d = S_HALT;
        end
      end
      S_WAIT: begin
        if (finish) state_d = halt_q ? S_HALT : S_IDLE;
        else        cnt_d   = cnt_q + 8'd1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State, access registers and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= issue;
      err_q   <= err_q | tmo | misalign;
      if (issue) begin
        addr_q  <= bus.Addr_m;
        wdata_q <= bus.WriteData_m;
        wr_q    <= bus.MemWrite_m;
        halt_q  <= bus.halt_m;
      end
    end
  end

  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_wr_o    = wr_q;
  assign bus.mem_en_o    = en_q;
  assign bus.stall_o     = issue
                         | ((state_q == S_WAIT) & ~bus.mem_done & ~tmo);
  assign bus.complete_o  = finish | misalign;
  assign bus.rdata_o     = (done & ~wr_q) ? bus.mem_rdata : 16'h0;
  assign bus.err_o       = err_q | tmo | misalign;
  assign bus.halted_o    = (state_q == S_HALT);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized scoreboard bench for mem_access_ctrl
// with a behavioural memory responder and transaction-level model.
module tb_mem_access_ctrl;
  localparam int TO = 15;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          req_cyc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    int          dly;
  } stb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic err_m = 1'b0;

  exp_t exp_q[$];
  stb_t stb_q[$];
  logic [15:0] ref_mem[int];
  logic [15:0] phys_mem[int];

  mem_access_if bus();

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    fails++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic idle_in();
    bus.Addr_m      = '0;
    bus.WriteData_m = '0;
    bus.MemRead_m   = 1'b0;
    bus.MemWrite_m  = 1'b0;
    bus.halt_m      = 1'b0;
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1.
  task automatic do_txn(input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input int dly,
                        input logic halt);
    exp_t e;
    stb_t s;
    bit   rej;
    bit   seen;
    int   lat;
    rej = 1'b0;
`ifdef ALIGN_CHK_EN
    rej = a[0];
`endif
    lat = rej ? 0 : ((dly < TO - 1 ? dly : TO - 1) + 1);
    e.req_cyc = cyc;
    e.lat     = lat;
    if (rej || dly > TO - 1) begin
      e.rdata = 16'h0;
      err_m   = 1'b1;
    end else begin
      e.rdata = wr ? 16'h0 : (ref_mem.exists(a) ? ref_mem[a] : 16'h0);
      if (wr) ref_mem[a] = d;
    end
    e.err = err_m;
    if (!rej) begin
      s.addr  = a;
      s.wdata = d;
      s.wr    = wr;
      s.dly   = dly;
      stb_q.push_back(s);
    end
    exp_q.push_back(e);
    bus.Addr_m      = a;
    bus.WriteData_m = d;
    bus.MemWrite_m  = wr;
    bus.MemRead_m   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.halt_m      = halt;
    seen = 1'b0;
    for (int k = 0; k <= TO + 4 && !seen; k++) begin
      @(negedge clk);
      #1;
      chk("stall", 16'(bus.stall_o), 16'(k < lat));
      if (bus.complete_o) seen = 1'b1;
    end
    if (!seen) bad("txn_no_complete");
    @(posedge clk);
    #1;
    idle_in();
  endtask

  // Memory responder: checks each strobe and answers after the scheduled delay.
  initial begin
    bit          busy;
    int          left;
    stb_t        s;
    logic [15:0] a, wd;
    logic        w;
    busy = 1'b0;
    left = 0;
    a = '0;
    wd = '0;
    w = 1'b0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_done  = 1'b0;
      bus.mem_rdata = '0;
      if (bus.mem_en_o) begin
        if (stb_q.size() == 0) begin
          bad("unexpected_strobe");
        end else begin
          s = stb_q.pop_front();
          chk("mem_addr", bus.mem_addr_o, s.addr);
          chk("mem_wr", 16'(bus.mem_wr_o), 16'(s.wr));
          if (s.wr) chk("mem_wdata", bus.mem_wdata_o, s.wdata);
          busy = (s.dly <= TO - 1);
          left = s.dly;
          a  = bus.mem_addr_o;
          wd = bus.mem_wdata_o;
          w  = bus.mem_wr_o;
        end
      end else if (busy) begin
        left--;
      end
      if (busy && left == 0) begin
        bus.mem_done = 1'b1;
        if (w) phys_mem[a] = wd;
        else bus.mem_rdata = phys_mem.exists(a) ? phys_mem[a] : 16'h0;
        busy = 1'b0;
      end
    end
  end

  // Monitor: every retirement pops one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst && bus.complete_o) begin
        if (exp_q.size() == 0) begin
          bad("unexpected_complete");
        end else begin
          e = exp_q.pop_front();
          chk("rdata", bus.rdata_o, e.rdata);
          chk("err", 16'(bus.err_o), 16'(e.err));
          chk("latency", 16'(cyc - e.req_cyc), 16'(e.lat));
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    logic [15:0] a;
    int          dly;
    idle_in();
    ref_mem[32'h0040]  = 16'hBEEF;
    phys_mem[32'h0040] = 16'hBEEF;
    #2;
    chk("rst_stall", 16'(bus.stall_o), 16'h0);
    chk("rst_complete", 16'(bus.complete_o), 16'h0);
    chk("rst_en", 16'(bus.mem_en_o), 16'h0);
    chk("rst_err", 16'(bus.err_o), 16'h0);
    chk("rst_halted", 16'(bus.halted_o), 16'h0);
    chk("rst_addr", bus.mem_addr_o, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_txn(1'b0, 16'h0040, 16'h0000, 1, 1'b0);
    do_txn(1'b1, 16'h0010, 16'h1234, 0, 1'b0);
    do_txn(1'b0, 16'h0041, 16'h0000, 1, 1'b0);
    do_txn(1'b0, 16'h0020, 16'h0000, 20, 1'b0);
    do_txn(1'b0, 16'h0010, 16'h0000, 2, 1'b0);

    for (int i = 0; i < 80; i++) begin
      a = 16'h0200 + 16'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) dly = $urandom_range(13, 18);
      else dly = $urandom_range(0, 4);
      do_txn(1'($urandom_range(0, 1)), a, 16'($urandom), dly, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    begin
      stb_t s;
      s.addr = 16'h0300;
      s.wdata = 16'h0;
      s.wr = 1'b0;
      s.dly = 6;
      stb_q.push_back(s);
    end
    bus.Addr_m    = 16'h0300;
    bus.MemRead_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_in();
    #1;
    chk("arst_stall", 16'(bus.stall_o), 16'h0);
    chk("arst_complete", 16'(bus.complete_o), 16'h0);
    chk("arst_en", 16'(bus.mem_en_o), 16'h0);
    chk("arst_err", 16'(bus.err_o), 16'h0);
    chk("arst_addr", bus.mem_addr_o, 16'h0);
    err_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    do_txn(1'b0, 16'h0040, 16'h0000, 1, 1'b1);
    @(negedge clk);
    chk("halt_after_txn", 16'(bus.halted_o), 16'h1);
    @(posedge clk);
    #1;
    bus.MemRead_m = 1'b1;
    bus.Addr_m    = 16'h0040;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("halt_stall", 16'(bus.stall_o), 16'h0);
      chk("halt_en", 16'(bus.mem_en_o), 16'h0);
      chk("halt_hold", 16'(bus.halted_o), 16'h1);
    end
    idle_in();

    rst = 1'b0;
    #1;
    chk("rst_halted_clr", 16'(bus.halted_o), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.halt_m = 1'b1;
    @(negedge clk);
    chk("halt_not_yet", 16'(bus.halted_o), 16'h0);
    @(posedge clk);
    #1;
    bus.halt_m    = 1'b0;
    bus.MemRead_m = 1'b1;
    @(negedge clk);
    chk("halt_idle", 16'(bus.halted_o), 16'h1);
    chk("halt_idle_stall", 16'(bus.stall_o), 16'h0);
    @(negedge clk);
    chk("halt_idle_en", 16'(bus.mem_en_o), 16'h0);
    idle_in();

    repeat (4) @(posedge clk);
    chk("exp_q_drained", 16'(exp_q.size()), 16'h0);
    chk("stb_q_drained", 16'(stb_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
